// File: rtl/secam_pkg.sv
// secam_pkg
//   Shared definitions for the SECAM chroma line sequencer:
//   - seq_state_e : per-line sequencing states
//   - *_DEF       : default line timing constants (625-line SECAM, 3456 clk/line)
//   - sat9()      : symmetric saturation of a signed 9-bit chroma sample
package secam_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BLANK  = 3'd1,
    SETTLE = 3'd2,
    ACTIVE = 3'd3,
    TAIL   = 3'd4
  } seq_state_e;

  localparam int LINE_CLOCKS_DEF    = 3456;
  localparam int ACTIVE_START_DEF   = 560;
  localparam int ACTIVE_LEN_DEF     = 2560;
  localparam int SETTLE_LEN_DEF     = 32;
  localparam int FILTER_LATENCY_DEF = 4;
  localparam int CHROMA_LIMIT_DEF   = 200;

  // Clamp x to [-lim, +lim]. Compared at 10 bits so -lim stays representable
  // and the 9-bit input range never wraps during the comparison.
  function automatic logic signed [8:0] sat9(input logic signed [8:0] x,
                                             input logic [7:0]        lim);
    logic signed [9:0] xw;
    logic signed [9:0] pos;
    logic signed [9:0] neg;
    xw  = {x[8], x};
    pos = {2'b00, lim};
    neg = -pos;
    if (xw > pos) begin
      sat9 = pos[8:0];
    end else if (xw < neg) begin
      sat9 = neg[8:0];
    end else begin
      sat9 = x;
    end
  endfunction

endpackage

// File: rtl/secam_align_delay.sv
// secam_align_delay
//   DEPTH-stage shift register with synchronous flush, used to line up the
//   active flag and line parity with the output of the pre-emphasis filter.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     flush      : synchronous clear of every stage (in-flight data dropped)
//     d          : WIDTH-bit input word
//     q          : WIDTH-bit word delayed by DEPTH clocks
module secam_align_delay #(
  parameter int DEPTH = 5,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_r [DEPTH];

  // Shift chain; a flush empties it in the same clock it is sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_r[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) stage_r[i] <= '0;
    end else begin
      stage_r[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage_r[i] <= stage_r[i-1];
    end
  end

  assign q = stage_r[DEPTH-1];

endmodule

// File: rtl/secam_chroma_line_sequencer.sv
// secam_chroma_line_sequencer
//   Per-line sequencer for the SECAM chroma pre-emphasis low-pass filter.
//   Alternates Dr/Db per line, clamps the selected sample, zero-feeds the
//   filter before (SETTLE) and after (TAIL) active video, and produces a
//   carrier gate aligned with the filter output.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     newline     : 1-clk line-start pulse (restarts h counter, forces BLANK)
//     newframe    : qualifies a coincident newline as first line of frame (Dr)
//     vblank      : sampled at newline; suppresses chroma for the whole line
//     db, dr      : signed 9-bit colour-difference samples
//     filter_in   : registered signed sample into the filter
//     chroma_en   : carrier gate, aligned to filter output
//     line_is_dr  : line parity, aligned to chroma_en
//     busy        : FSM in SETTLE, ACTIVE or TAIL (combinational)
module secam_chroma_line_sequencer
  import secam_pkg::*;
#(
  parameter int LINE_CLOCKS    = LINE_CLOCKS_DEF,
  parameter int ACTIVE_START   = ACTIVE_START_DEF,
  parameter int ACTIVE_LEN     = ACTIVE_LEN_DEF,
  parameter int SETTLE_LEN     = SETTLE_LEN_DEF,
  parameter int FILTER_LATENCY = FILTER_LATENCY_DEF,
  parameter int CHROMA_LIMIT   = CHROMA_LIMIT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       newline,
  input  logic       newframe,
  input  logic       vblank,
  input  logic [8:0] db,
  input  logic [8:0] dr,
  output logic [8:0] filter_in,
  output logic       chroma_en,
  output logic       line_is_dr,
  output logic       busy
);

  localparam int HW = (LINE_CLOCKS > 1) ? $clog2(LINE_CLOCKS) : 1;
  localparam int TW = (FILTER_LATENCY > 1) ? $clog2(FILTER_LATENCY) : 1;

  localparam logic [HW-1:0] H_LAST   = HW'(LINE_CLOCKS - 1);
  localparam logic [HW-1:0] H_SETTLE = HW'(ACTIVE_START - SETTLE_LEN);
  localparam logic [HW-1:0] H_ACTIVE = HW'(ACTIVE_START);
  localparam logic [HW-1:0] H_END    = HW'(ACTIVE_START + ACTIVE_LEN);
  localparam logic [TW-1:0] T_LAST   = TW'(FILTER_LATENCY - 1);
  localparam logic [7:0]    LIMIT    = 8'(CHROMA_LIMIT);

  seq_state_e        state_r;
  seq_state_e        state_nxt_s;
  logic [HW-1:0]     h_cnt_r;
  logic [HW-1:0]     h_nxt_s;
  logic [TW-1:0]     tail_cnt_r;
  logic [TW-1:0]     tail_nxt_s;
  logic              is_dr_r;
  logic              vblank_line_r;
  logic signed [8:0] sample_s;
  logic [8:0]        filter_in_r;
  logic [1:0]        align_d_s;
  logic [1:0]        align_q_s;

  // Next horizontal count: cleared by newline, otherwise saturating increment.
  always_comb begin
    h_nxt_s = h_cnt_r;
    if (newline) begin
      h_nxt_s = '0;
    end else if (h_cnt_r != H_LAST) begin
      h_nxt_s = h_cnt_r + HW'(1);
    end else begin
      h_nxt_s = h_cnt_r;
    end
  end

  // Next-state logic. Transitions compare against the *next* h count so the
  // state is already SETTLE/ACTIVE/TAIL in the clock whose h_cnt equals the
  // boundary value.
  always_comb begin
    state_nxt_s = state_r;
    tail_nxt_s  = tail_cnt_r;
    if (newline) begin
      state_nxt_s = BLANK;
      tail_nxt_s  = '0;
    end else begin
      case (state_r)
        IDLE: begin
          state_nxt_s = IDLE;
        end
        BLANK: begin
          if ((h_nxt_s == H_SETTLE) && !vblank_line_r) state_nxt_s = SETTLE;
          else                                         state_nxt_s = BLANK;
        end
        SETTLE: begin
          if (h_nxt_s == H_ACTIVE) state_nxt_s = ACTIVE;
          else                     state_nxt_s = SETTLE;
        end
        ACTIVE: begin
          if (h_nxt_s == H_END) begin
            state_nxt_s = TAIL;
            tail_nxt_s  = '0;
          end else begin
            state_nxt_s = ACTIVE;
          end
        end
        TAIL: begin
          if (tail_cnt_r == T_LAST) begin
            state_nxt_s = BLANK;
          end else begin
            state_nxt_s = TAIL;
            tail_nxt_s  = tail_cnt_r + TW'(1);
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // State, counters, and per-line parity/vblank captured at newline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      h_cnt_r       <= '0;
      tail_cnt_r    <= '0;
      is_dr_r       <= 1'b0;
      vblank_line_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      h_cnt_r    <= h_nxt_s;
      tail_cnt_r <= tail_nxt_s;
      if (newline) begin
        is_dr_r       <= newframe ? 1'b1 : ~is_dr_r;
        vblank_line_r <= vblank;
      end else begin
        is_dr_r       <= is_dr_r;
        vblank_line_r <= vblank_line_r;
      end
    end
  end

  assign sample_s = sat9(is_dr_r ? $signed(dr) : $signed(db), LIMIT);

  // Filter feed: clamped sample in ACTIVE, zeros otherwise. A newline zeroes
  // it at once so an aborted line leaves no stray sample behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filter_in_r <= 9'd0;
    end else if (newline) begin
      filter_in_r <= 9'd0;
    end else if (state_r == ACTIVE) begin
      filter_in_r <= sample_s;
    end else begin
      filter_in_r <= 9'd0;
    end
  end

  assign align_d_s = {is_dr_r, (state_r == ACTIVE)};

  // One stage matches the filter_in register, the rest the filter latency.
  // Flushing on every newline is harmless in IDLE, where the chain is empty.
  secam_align_delay #(
    .DEPTH(1 + FILTER_LATENCY),
    .WIDTH(2)
  ) u_align (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(newline),
    .d    (align_d_s),
    .q    (align_q_s)
  );

  assign filter_in  = filter_in_r;
  assign chroma_en  = align_q_s[0];
  assign line_is_dr = align_q_s[1];
  assign busy       = (state_r == SETTLE) || (state_r == ACTIVE) || (state_r == TAIL);

endmodule

// File: tb/tb_secam_chroma_line_sequencer.sv
// Scoreboard bench for secam_chroma_line_sequencer with a short test line:
// 64 clk/line, active h=16..35, settle from h=12, filter latency 4, limit 100.
module tb_secam_chroma_line_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       newline, newframe, vblank;
  logic [8:0] db, dr;
  logic [8:0] filter_in;
  logic       chroma_en, line_is_dr, busy;

  typedef struct {
    logic signed [8:0] val;
    logic              dr;
  } beat_t;

  beat_t             exp_q[$];
  int                n_cmp = 0;
  int                n_err = 0;
  logic signed [8:0] hist [5];

  always #5 clk = ~clk;

  secam_chroma_line_sequencer #(
    .LINE_CLOCKS(64), .ACTIVE_START(16), .ACTIVE_LEN(20),
    .SETTLE_LEN(4), .FILTER_LATENCY(4), .CHROMA_LIMIT(100)
  ) dut (
    .clk(clk), .rst_n(rst_n), .newline(newline), .newframe(newframe),
    .vblank(vblank), .db(db), .dr(dr), .filter_in(filter_in),
    .chroma_en(chroma_en), .line_is_dr(line_is_dr), .busy(busy)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: chroma_en is the valid strobe; the filter input it refers to
  // was presented 4 clocks earlier (filter latency).
  initial begin
    beat_t e;
    for (int i = 0; i < 5; i++) hist[i] = 9'sd0;
    forever begin
      @(negedge clk);
      for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = $signed(filter_in);
      if (rst_n === 1'b1 && chroma_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL beat_unexpected: got sample %0d with nothing expected at t=%0t",
                   hist[4], $time);
        end else begin
          e = exp_q.pop_front();
          chk("beat_sample", int'(hist[4]), int'(e.val));
          chk("beat_line_is_dr", int'(line_is_dr), int'(e.dr));
        end
      end
    end
  end

  // Drive one line: newline in the current clock, then n clocks (h=0..n-1)
  // with window checks. Returns in the clock with h=n.
  task automatic run_line(input logic nf, input logic vb,
                          input logic signed [8:0] dbv, input logic signed [8:0] drv,
                          input int n, input logic signed [8:0] exp_val,
                          input logic exp_dr, input int beats);
    logic act;
    newline = 1'b1; newframe = nf; vblank = vb; db = dbv; dr = drv;
    for (int k = 0; k < beats; k++) exp_q.push_back('{exp_val, exp_dr});
    @(posedge clk); #1;
    newline = 1'b0; newframe = 1'b0; vblank = 1'b0;
    act = !vb;
    for (int h = 0; h < n; h++) begin
      chk("busy", int'(busy), int'(act && h >= 12 && h <= 39));
      chk("chroma_en", int'(chroma_en), int'(act && h >= 21 && h <= 40));
      if (!(act && h >= 17 && h <= 36)) chk("filter_zero", int'($signed(filter_in)), 0);
      @(posedge clk); #1;
    end
  endtask

  task automatic idle_check(input int n, input string nm);
    for (int i = 0; i < n; i++) begin
      chk({nm, "_filter"}, int'(filter_in), 0);
      chk({nm, "_chroma"}, int'(chroma_en), 0);
      chk({nm, "_busy"}, int'(busy), 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; newline = 1'b0; newframe = 1'b0; vblank = 1'b0;
    db = 9'd0; dr = 9'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_line_is_dr", int'(line_is_dr), 0);
    rst_n = 1'b1;
    idle_check(200, "idle");

    // frame start: Dr line, then Db line with the same inputs
    run_line(1'b1, 1'b0, -9'sd30, 9'sd50, 63, 9'sd50, 1'b1, 20);
    run_line(1'b0, 1'b0, -9'sd30, 9'sd50, 63, -9'sd30, 1'b0, 20);
    // saturation: +255 -> 100, 99 unchanged, -256 -> -100, -150 -> -100
    run_line(1'b1, 1'b0, 9'sd0, 9'sd255, 63, 9'sd100, 1'b1, 20);
    run_line(1'b0, 1'b0, 9'sd99, 9'sd0, 63, 9'sd99, 1'b0, 20);
    run_line(1'b0, 1'b0, 9'sd0, -9'sd256, 63, -9'sd100, 1'b1, 20);
    run_line(1'b0, 1'b0, -9'sd150, 9'sd0, 63, -9'sd100, 1'b0, 20);
    // abort at h=25: chroma_en seen only at h=21..25
    run_line(1'b0, 1'b0, 9'sd0, 9'sd50, 25, 9'sd50, 1'b1, 5);
    run_line(1'b0, 1'b0, -9'sd30, 9'sd0, 63, -9'sd30, 1'b0, 20);
    // vblank line (Dr parity, suppressed), next line is Db
    run_line(1'b0, 1'b1, 9'sd40, 9'sd40, 63, 9'sd0, 1'b0, 0);
    run_line(1'b0, 1'b0, 9'sd20, 9'sd0, 63, 9'sd20, 1'b0, 20);
    // reset at h=20 of a Dr line
    run_line(1'b0, 1'b0, 9'sd0, 9'sd70, 20, 9'sd0, 1'b0, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_filter", int'(filter_in), 0);
    chk("rst_mid_chroma", int'(chroma_en), 0);
    chk("rst_mid_line_is_dr", int'(line_is_dr), 0);
    chk("rst_mid_busy", int'(busy), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_check(20, "post_rst");
    // parity cleared by reset, so a plain newline gives a Dr line
    run_line(1'b0, 1'b0, 9'sd0, 9'sd70, 63, 9'sd70, 1'b1, 20);
    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
